// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared LSU types and constants: widths, exception causes,
//                the AGU response queue entry and the branch-mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int BR_W   = 20;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam int ROB_W  = 7;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

    // One buffered AGU response; the field "signed" is spelled is_signed
    // because signed is a reserved word.
    typedef struct packed {
        logic              valid;
        logic [BR_W-1:0]   br_mask;
        logic [ROB_W-1:0]  rob_idx;
        logic              is_load;
        logic [1:0]        size;
        logic              is_signed;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              mxcpt;
    } agu_entry_t;

    // Clears the bits of branches that resolved this cycle.
    function automatic logic [BR_W-1:0] br_mask_update(
        input logic [BR_W-1:0] mask,
        input logic [BR_W-1:0] resolve
    );
        return mask & ~resolve;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agu_resp_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : agu_resp_queue_if
//  Description : Bundle of the AGU response input, branch update, flush,
//                cache request, exception and status signals of the queue.
//                slave = queue side, master = surrounding pipeline side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface agu_resp_queue_if
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [BR_W-1:0]   in_br_mask;
    logic [ROB_W-1:0]  in_rob_idx;
    logic              in_is_load;
    logic [1:0]        in_mem_size;
    logic              in_mem_signed;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_mxcpt;

    logic [BR_W-1:0]   brupdate_resolve_mask;
    logic [BR_W-1:0]   brupdate_mispredict_mask;
    logic              flush;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [1:0]        mem_req_size;
    logic              mem_req_signed;
    logic              mem_req_is_load;
    logic [ROB_W-1:0]  mem_req_rob_idx;
    logic [BR_W-1:0]   mem_req_br_mask;

    logic              xcpt_valid;
    logic [ROB_W-1:0]  xcpt_rob_idx;
    logic [ADDR_W-1:0] xcpt_addr;
    logic [3:0]        xcpt_cause;

    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport slave (
        input  in_valid, in_br_mask, in_rob_idx, in_is_load, in_mem_size,
               in_mem_signed, in_addr, in_data, in_mxcpt,
               brupdate_resolve_mask, brupdate_mispredict_mask, flush,
               mem_req_ready,
        output in_ready, mem_req_valid, mem_req_addr, mem_req_data,
               mem_req_size, mem_req_signed, mem_req_is_load,
               mem_req_rob_idx, mem_req_br_mask,
               xcpt_valid, xcpt_rob_idx, xcpt_addr, xcpt_cause,
               count, overflow
    );

    modport master (
        output in_valid, in_br_mask, in_rob_idx, in_is_load, in_mem_size,
               in_mem_signed, in_addr, in_data, in_mxcpt,
               brupdate_resolve_mask, brupdate_mispredict_mask, flush,
               mem_req_ready,
        input  in_ready, mem_req_valid, mem_req_addr, mem_req_data,
               mem_req_size, mem_req_signed, mem_req_is_load,
               mem_req_rob_idx, mem_req_br_mask,
               xcpt_valid, xcpt_rob_idx, xcpt_addr, xcpt_cause,
               count, overflow
    );

endinterface
`default_nettype wire

// File: rtl/agu_resp_queue.sv
`default_nettype none
// ============================================================================
//  Module      : agu_resp_queue
//  Description : In-order circular buffer of AGU responses. The head either
//                issues to the data cache (ready/valid), retires as a
//                misalignment exception pulse, or is dropped silently when
//                it was killed by a branch misprediction.
//  Revision    : 1.0 - initial release
// ============================================================================
module agu_resp_queue
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    agu_resp_queue_if.slave bus
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    agu_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    agu_entry_t       w_head;
    agu_entry_t       w_new;
    logic             w_nonempty;
    logic             w_head_live;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_mem_valid;
    logic             w_xcpt_valid;

    assign w_head     = r_entries[r_head];
    assign w_nonempty = (r_count != '0);
    // A full queue refuses even if the head pops this cycle.
    assign w_in_ready = (r_count < DEPTH_CNT);

    // Head liveness, drain decision and enqueue decision for this cycle.
    always_comb begin
        w_head_live  = w_nonempty && w_head.valid &&
                       ((w_head.br_mask & bus.brupdate_mispredict_mask) == '0);
        w_mem_valid  = w_head_live && !w_head.mxcpt && !bus.flush;
        w_xcpt_valid = w_head_live &&  w_head.mxcpt && !bus.flush;
        // Dead heads and exception heads leave unconditionally; live
        // requests wait for the cache.
        w_pop        = w_nonempty && !bus.flush &&
                       (!w_head_live || w_head.mxcpt || bus.mem_req_ready);
        w_push       = bus.in_valid && w_in_ready && !bus.flush;
    end

    // Incoming entry, already resolve-masked and killed if its branch
    // mispredicts in the arrival cycle.
    always_comb begin
        w_new           = '0;
        w_new.valid     = ((bus.in_br_mask & bus.brupdate_mispredict_mask) == '0);
        w_new.br_mask   = br_mask_update(bus.in_br_mask, bus.brupdate_resolve_mask);
        w_new.rob_idx   = bus.in_rob_idx;
        w_new.is_load   = bus.in_is_load;
        w_new.size      = bus.in_mem_size;
        w_new.is_signed = bus.in_mem_signed;
        w_new.addr      = bus.in_addr;
        w_new.data      = bus.in_data;
        w_new.mxcpt     = bus.in_mxcpt;
    end

    // Storage, pointers, occupancy and sticky overflow; reset beats flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].br_mask <= br_mask_update(r_entries[i].br_mask,
                                                       bus.brupdate_resolve_mask);
                if ((r_entries[i].br_mask & bus.brupdate_mispredict_mask) != '0) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            // Tail never equals head on a push while the queue is non-empty,
            // so this write cannot collide with the pop above.
            if (w_push) begin
                r_entries[r_tail] <= w_new;
                r_tail            <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (bus.in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.count           = r_count;
    assign bus.overflow        = r_overflow;

    assign bus.mem_req_valid   = w_mem_valid;
    assign bus.mem_req_addr    = w_head.addr;
    assign bus.mem_req_data    = w_head.data;
    assign bus.mem_req_size    = w_head.size;
    assign bus.mem_req_signed  = w_head.is_signed;
    assign bus.mem_req_is_load = w_head.is_load;
    assign bus.mem_req_rob_idx = w_head.rob_idx;
    assign bus.mem_req_br_mask = br_mask_update(w_head.br_mask, bus.brupdate_resolve_mask);

    // Exception fields read zero except during the retire pulse.
    assign bus.xcpt_valid      = w_xcpt_valid;
    assign bus.xcpt_rob_idx    = w_xcpt_valid ? w_head.rob_idx : '0;
    assign bus.xcpt_addr       = w_xcpt_valid ? w_head.addr : '0;
    assign bus.xcpt_cause      = !w_xcpt_valid ? 4'd0 :
                                 (w_head.is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN);

endmodule
`default_nettype wire

// File: tb/tb_agu_resp_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agu_resp_queue
//  Description : Scoreboard bench for agu_resp_queue: expected cache
//                requests and exceptions are queued at enqueue time and
//                matched by a monitor as the queue emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agu_resp_queue;
    import lsu_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
        logic              is_load;
        logic [1:0]        size;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
        logic [3:0]        cause;
    } xcpt_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    req_t  exp_q[$];
    xcpt_t xq[$];

    agu_resp_queue_if #(.DEPTH(4)) bus();

    agu_resp_queue #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Monitor: every emitted request / exception must match the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL mem_req_unexpected: got addr=%h rob=%h, required none",
                             bus.mem_req_addr, bus.mem_req_rob_idx);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    if (bus.mem_req_addr !== e.addr || bus.mem_req_rob_idx !== e.rob ||
                        bus.mem_req_is_load !== e.is_load || bus.mem_req_size !== e.size ||
                        bus.mem_req_data !== e.data) begin
                        fails++;
                        $display("FAIL mem_req_fields: got addr=%h rob=%h ld=%b sz=%0d data=%h, required addr=%h rob=%h ld=%b sz=%0d data=%h",
                                 bus.mem_req_addr, bus.mem_req_rob_idx, bus.mem_req_is_load,
                                 bus.mem_req_size, bus.mem_req_data,
                                 e.addr, e.rob, e.is_load, e.size, e.data);
                    end
                end
            end
            if (bus.xcpt_valid) begin
                checks++;
                if (xq.size() == 0) begin
                    fails++;
                    $display("FAIL xcpt_unexpected: got rob=%h addr=%h, required none",
                             bus.xcpt_rob_idx, bus.xcpt_addr);
                end else begin
                    xcpt_t x;
                    x = xq.pop_front();
                    if (bus.xcpt_rob_idx !== x.rob || bus.xcpt_addr !== x.addr ||
                        bus.xcpt_cause !== x.cause) begin
                        fails++;
                        $display("FAIL xcpt_fields: got rob=%h addr=%h cause=%0d, required rob=%h addr=%h cause=%0d",
                                 bus.xcpt_rob_idx, bus.xcpt_addr, bus.xcpt_cause,
                                 x.rob, x.addr, x.cause);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid                 = 1'b0;
        bus.in_br_mask               = '0;
        bus.in_rob_idx               = '0;
        bus.in_is_load               = 1'b0;
        bus.in_mem_size              = 2'd0;
        bus.in_mem_signed            = 1'b0;
        bus.in_addr                  = '0;
        bus.in_data                  = '0;
        bus.in_mxcpt                 = 1'b0;
        bus.brupdate_resolve_mask    = '0;
        bus.brupdate_mispredict_mask = '0;
        bus.flush                    = 1'b0;
    endtask

    task automatic drive_in(input logic ld, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] rob,
                            input logic [BR_W-1:0] m, input logic mx);
        bus.in_valid      = 1'b1;
        bus.in_is_load    = ld;
        bus.in_mem_size   = sz;
        bus.in_mem_signed = ld;
        bus.in_addr       = a;
        bus.in_data       = d;
        bus.in_rob_idx    = rob;
        bus.in_br_mask    = m;
        bus.in_mxcpt      = mx;
    endtask

    // Enqueue one entry over one clock; returns 2 time units after the edge.
    task automatic push_entry(input logic ld, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] rob,
                              input logic [BR_W-1:0] m, input logic mx, input bit expect_out);
        if (expect_out) begin
            if (mx) begin
                xcpt_t x;
                x.addr = a; x.rob = rob;
                x.cause = ld ? 4'd4 : 4'd6;
                xq.push_back(x);
            end else begin
                req_t e;
                e.addr = a; e.rob = rob; e.is_load = ld; e.size = sz; e.data = d;
                exp_q.push_back(e);
            end
        end
        drive_in(ld, sz, a, d, rob, m, mx);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic cycle();
        @(posedge clock); #2;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((bus.count != '0 || exp_q.size() != 0 || xq.size() != 0) && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 50) begin
            fails++;
            $display("FAIL drain_timeout: count=%0d pending_req=%0d pending_xcpt=%0d, required all 0",
                     bus.count, exp_q.size(), xq.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.count !== 3'd0 || bus.overflow !== 1'b0 ||
            bus.mem_req_valid !== 1'b0 || bus.xcpt_valid !== 1'b0 ||
            bus.mem_req_addr !== '0 || bus.xcpt_cause !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b cnt=%0d ovf=%b mv=%b xv=%b addr=%h cause=%0d, required 1 0 0 0 0 0 0",
                     bus.in_ready, bus.count, bus.overflow, bus.mem_req_valid,
                     bus.xcpt_valid, bus.mem_req_addr, bus.xcpt_cause);
        end
    endtask

    task automatic test_in_order();
        bus.mem_req_ready = 1'b1;
        push_entry(1'b1, 2'd3, 40'h1000, 64'h0, 7'h01, '0, 1'b0, 1'b1);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h1000) begin
            fails++;
            $display("FAIL in_order_first: valid=%b addr=%h, required 1 1000", bus.mem_req_valid, bus.mem_req_addr);
        end
        push_entry(1'b1, 2'd3, 40'h1008, 64'h0, 7'h02, '0, 1'b0, 1'b1);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h1008 || bus.count !== 3'd1) begin
            fails++;
            $display("FAIL in_order_second: valid=%b addr=%h count=%0d, required 1 1008 1",
                     bus.mem_req_valid, bus.mem_req_addr, bus.count);
        end
        cycle();
        checks++;
        if (bus.count !== 3'd0 || bus.mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL in_order_empty: count=%0d valid=%b, required 0 0", bus.count, bus.mem_req_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [ADDR_W-1:0] a;
            a = 40'h6000 + 40'(i * 8);
            push_entry(i[0], 2'(i), a, 64'hA5A5_0000_0000_0000 | 64'(i), 7'(8'h30 + i), '0, 1'b0, 1'b1);
            checks++;
            if (bus.count !== 3'd1 || bus.mem_req_addr !== a || bus.mem_req_valid !== 1'b1) begin
                fails++;
                $display("FAIL back_to_back[%0d]: count=%0d addr=%h valid=%b, required 1 %h 1",
                         i, bus.count, bus.mem_req_addr, bus.mem_req_valid, a);
            end
        end
        wait_drain();
    endtask

    task automatic test_overflow();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_entry(1'b0, 2'd3, 40'h2000 + 40'(i * 8), 64'hDEAD_0000 + 64'(i), 7'(i), '0, 1'b0, 1'b1);
        end
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || bus.overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_state: count=%0d ready=%b ovf=%b, required 4 0 0", bus.count, bus.in_ready, bus.overflow);
        end
        push_entry(1'b0, 2'd3, 40'h2100, 64'hBAD, 7'h7F, '0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd4 || bus.overflow !== 1'b1 || bus.mem_req_addr !== 40'h2000) begin
            fails++;
            $display("FAIL overflow_set: count=%0d ovf=%b head=%h, required 4 1 2000",
                     bus.count, bus.overflow, bus.mem_req_addr);
        end
        bus.mem_req_ready = 1'b1;
        wait_drain();
        checks++;
        if (bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", bus.overflow);
        end
    endtask

    task automatic test_misaligned();
        bus.mem_req_ready = 1'b1;
        push_entry(1'b0, 2'd2, 40'h1003, 64'h55, 7'h12, '0, 1'b1, 1'b1);
        checks++;
        if (bus.xcpt_valid !== 1'b1 || bus.xcpt_cause !== 4'd6 || bus.xcpt_rob_idx !== 7'h12 ||
            bus.xcpt_addr !== 40'h1003 || bus.mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL st_misalign: xv=%b cause=%0d rob=%h addr=%h mv=%b, required 1 6 12 1003 0",
                     bus.xcpt_valid, bus.xcpt_cause, bus.xcpt_rob_idx, bus.xcpt_addr, bus.mem_req_valid);
        end
        push_entry(1'b1, 2'd3, 40'h1010, 64'h0, 7'h13, '0, 1'b0, 1'b1);
        checks++;
        if (bus.xcpt_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h1010) begin
            fails++;
            $display("FAIL after_xcpt: xv=%b mv=%b addr=%h, required 0 1 1010",
                     bus.xcpt_valid, bus.mem_req_valid, bus.mem_req_addr);
        end
        push_entry(1'b1, 2'd1, 40'h1011, 64'h0, 7'h14, '0, 1'b1, 1'b1);
        checks++;
        if (bus.xcpt_valid !== 1'b1 || bus.xcpt_cause !== 4'd4) begin
            fails++;
            $display("FAIL ld_misalign: xv=%b cause=%0d, required 1 4", bus.xcpt_valid, bus.xcpt_cause);
        end
        wait_drain();
    endtask

    task automatic test_branch_kill();
        bus.mem_req_ready = 1'b0;
        push_entry(1'b1, 2'd3, 40'h3000, 64'h0, 7'h20, 20'h1, 1'b0, 1'b0);
        push_entry(1'b1, 2'd3, 40'h3008, 64'h0, 7'h21, 20'h2, 1'b0, 1'b1);
        push_entry(1'b1, 2'd3, 40'h3010, 64'h0, 7'h22, 20'h0, 1'b0, 1'b1);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_br_mask !== 20'h1) begin
            fails++;
            $display("FAIL br_head: valid=%b mask=%h, required 1 00001", bus.mem_req_valid, bus.mem_req_br_mask);
        end
        bus.brupdate_mispredict_mask = 20'h1;
        bus.brupdate_resolve_mask    = 20'h2;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_kill_same_cycle: valid=%b, required 0", bus.mem_req_valid);
        end
        @(posedge clock); #1;
        bus.brupdate_mispredict_mask = '0;
        bus.brupdate_resolve_mask    = '0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h3008 ||
            bus.mem_req_br_mask !== 20'h0 || bus.count !== 3'd2) begin
            fails++;
            $display("FAIL br_next_head: valid=%b addr=%h mask=%h count=%0d, required 1 3008 0 2",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_br_mask, bus.count);
        end
        bus.mem_req_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_kill_waiting();
        bus.mem_req_ready = 1'b0;
        push_entry(1'b0, 2'd3, 40'h4000, 64'h11, 7'h40, 20'h4, 1'b0, 1'b0);
        push_entry(1'b0, 2'd3, 40'h4008, 64'h22, 7'h41, 20'h0, 1'b0, 1'b1);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h4000) begin
            fails++;
            $display("FAIL wait_head: valid=%b addr=%h, required 1 4000", bus.mem_req_valid, bus.mem_req_addr);
        end
        bus.brupdate_mispredict_mask = 20'h4;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.xcpt_valid !== 1'b0) begin
            fails++;
            $display("FAIL wait_kill: mv=%b xv=%b, required 0 0", bus.mem_req_valid, bus.xcpt_valid);
        end
        @(posedge clock); #1;
        bus.brupdate_mispredict_mask = '0;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h4008 || bus.count !== 3'd1) begin
            fails++;
            $display("FAIL wait_pop: valid=%b addr=%h count=%0d, required 1 4008 1",
                     bus.mem_req_valid, bus.mem_req_addr, bus.count);
        end
        bus.mem_req_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_flush();
        do_reset();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_entry(1'b1, 2'd3, 40'h5100 + 40'(i * 8), 64'h0, 7'(8'h50 + i), '0, 1'b0, 1'b0);
        end
        drive_in(1'b1, 2'd3, 40'h5200, 64'h0, 7'h5F, '0, 1'b0);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle_valid: valid=%b, required 0", bus.mem_req_valid);
        end
        @(posedge clock); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.mem_req_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_after: count=%0d valid=%b ovf=%b ready=%b, required 0 0 0 1",
                     bus.count, bus.mem_req_valid, bus.overflow, bus.in_ready);
        end
        bus.mem_req_ready = 1'b1;
        push_entry(1'b1, 2'd0, 40'h5000, 64'h0, 7'h5A, '0, 1'b0, 1'b1);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 40'h5000) begin
            fails++;
            $display("FAIL flush_restart: valid=%b addr=%h, required 1 5000", bus.mem_req_valid, bus.mem_req_addr);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_burst();
        bus.mem_req_ready = 1'b0;
        push_entry(1'b0, 2'd3, 40'h7000, 64'hFFFF, 7'h70, 20'h8, 1'b0, 1'b0);
        push_entry(1'b0, 2'd3, 40'h7008, 64'hEEEE, 7'h71, 20'h8, 1'b0, 1'b0);
        drive_in(1'b0, 2'd3, 40'h7010, 64'hDDDD, 7'h72, 20'h8, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.mem_req_valid !== 1'b0 || bus.xcpt_valid !== 1'b0 ||
            bus.mem_req_addr !== '0 || bus.mem_req_data !== '0 || bus.mem_req_br_mask !== '0) begin
            fails++;
            $display("FAIL reset_mid_burst: cnt=%0d rdy=%b ovf=%b mv=%b xv=%b addr=%h data=%h mask=%h, required 0 1 0 0 0 0 0 0",
                     bus.count, bus.in_ready, bus.overflow, bus.mem_req_valid, bus.xcpt_valid,
                     bus.mem_req_addr, bus.mem_req_data, bus.mem_req_br_mask);
        end
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        idle_inputs();
        bus.mem_req_ready = 1'b0;
        test_reset();
        test_in_order();
        test_back_to_back();
        test_overflow();
        test_misaligned();
        test_branch_kill();
        test_kill_waiting();
        test_flush();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu_resp_queue.md
# agu_resp_queue

Buffers address-generation responses (address, store data, uop tags, misalignment flag) between the memory address-calculation unit and the data-cache request port. Entries drain in order to the cache with a ready/valid handshake, or to the exception port if misaligned. Every buffered entry tracks branch resolution and misprediction every cycle. Sits in the LSU front end, downstream of the AGU response.

## Interface
- DEPTH, 4, number of entries; must be a power of two ≥2
- BR_W, 20, branch-mask width
- ADDR_W, 40, address width
- DATA_W, 64, store-data width
- ROB_W, 7, ROB index width

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  AGU response valid
- in_ready  out  1  queue can accept; high when count < DEPTH
- in_br_mask  in  BR_W  uop branch mask, already resolve-masked by the AGU
- in_rob_idx  in  ROB_W  ROB index
- in_is_load  in  1  1 = load, 0 = store
- in_mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- in_mem_signed  in  1  sign-extend load
- in_addr  in  ADDR_W  computed address
- in_data  in  DATA_W  store data
- in_mxcpt  in  1  misaligned access
- brupdate_resolve_mask  in  BR_W  branches resolved this cycle
- brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle
- flush  in  1  pipeline flush; empties the queue
- mem_req_valid  out  1  cache request valid
- mem_req_ready  in  1  cache accepts
- mem_req_addr / _data / _size / _signed / _is_load / _rob_idx / _br_mask  out  ADDR_W / DATA_W / 2 / 1 / 1 / ROB_W / BR_W  fields of the head entry
- xcpt_valid  out  1  single-cycle pulse: misaligned head retired
- xcpt_rob_idx  out  ROB_W  ROB index of the faulting uop
- xcpt_addr  out  ADDR_W  faulting address
- xcpt_cause  out  4  4 = load misaligned, 6 = store misaligned
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky; set when in_valid arrives while in_ready is low

## Operation
- Storage is a circular FIFO with head and tail pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Each entry carries a valid bit.
- **Enqueue**
  - Occurs when in_valid & in_ready & ~flush.
  - Stored mask = in_br_mask & ~resolve.
  - The entry is stored invalid (a "bubble") if (in_br_mask & mispredict) != 0.
  - When in_valid arrives while in_ready is low, the request is dropped and overflow is set.
- **Per-cycle update of every entry**
  - mask ← mask & ~resolve_mask.
  - valid ← 0 if (mask & mispredict_mask) != 0.
- **Head status**
  - head_live = entry valid & (mask & mispredict) == 0.
- **Head drain; exactly one of these applies each cycle**
  - Killed or invalid head: popped silently in one cycle, with no output.
  - head_live & mxcpt: xcpt_valid pulses for one cycle and the head pops. mem_req_valid stays 0.
  - head_live & ~mxcpt: mem_req_valid = 1 and the head pops on mem_req_ready.
  - mem_req_valid must not drop while waiting for ready unless the head is killed.
- **Output mask**
  - mem_req_br_mask = stored mask & ~resolve_mask (combinational).
- **Flush**
  - Next cycle, all valid bits are 0, head = tail = 0 and count = 0.
  - A same-cycle enqueue is discarded without setting overflow.
  - mem_req_valid and xcpt_valid are forced to 0 in the flush cycle.
- **Push and pop**
  - Same-cycle push and pop is allowed; count is unchanged.
  - in_ready ignores a same-cycle pop, so a full queue never accepts.
- **Reset**
  - Takes precedence over flush.
  - All outputs 0: in_ready = 1, count = 0, overflow = 0, mem_req_valid = 0, xcpt_valid = 0, data outputs 0. Pointers are 0.

## Timing
- Enqueue-to-head latency is 1 cycle: push at cycle N gives mem_req_valid at N+1 when the queue was empty.
- Throughput is one push and one pop per cycle.
- Kill is visible the same cycle: a mispredict at cycle N drops mem_req_valid at cycle N for a matching head.
- A silent pop of a killed head costs one cycle per entry.
- xcpt_valid is a 1-cycle pulse, with no handshake.
- overflow clears only on reset.

## Structure
- Shared package lsu_pkg holds:
  - constants CAUSE_LD_MISALIGN = 4 and CAUSE_ST_MISALIGN = 6;
  - BR_W;
  - packed struct agu_entry_t {valid, br_mask, rob_idx, is_load, size, signed, addr, data, mxcpt};
  - function br_mask_update(mask, resolve).
- Single module; no sub-module. The FIFO storage stays inline as an entry array.

## Test plan
- Push loads at addr 0x1000 and 0x1008 with mem_req_ready = 1 → mem_req_valid on cycles 1–2, addrs in order, count returns to 0.
- Fill 4 entries with ready = 0, then in_valid on a 5th → in_ready = 0, overflow = 1, count = 4; the 5th entry never appears on output.
- Store with in_mxcpt = 1, rob_idx = 0x12, addr 0x1003 → xcpt_valid pulse, cause = 6, xcpt_rob_idx = 0x12, mem_req_valid stays 0; the next entry issues the following cycle.
- Entries with br_mask 0x1 / 0x2 / 0x0, then mispredict_mask = 0x1 → entry 0 is never issued; the 0x2 entry issues next. With resolve = 0x2 the same cycle, the 0x2 entry shows mem_req_br_mask = 0.
- Head waiting with ready = 0 and br_mask 0x4; mispredict 0x4 → mem_req_valid drops the same cycle and the head pops silently.
- 3 entries queued, flush asserted together with in_valid → next cycle count = 0, mem_req_valid = 0, overflow = 0; reset mid-burst gives all outputs 0.
